// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the 1A2B round judge
package game_pkg;

  localparam int DIGIT_W     = 4;
  localparam int DIGITS      = 4;
  localparam int MAX_CHANCES = 5;
  localparam int IDX_W       = 2;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    COMPARE,
    DECIDE
  } judge_state_t;

  // Digit k sits at [DIGIT_W*k +: DIGIT_W]; digit DIGITS-1 is the most significant.
  function automatic digit_t get_digit(input logic [DIGITS*DIGIT_W-1:0] v,
                                       input logic [IDX_W-1:0] k);
    return v[DIGIT_W*k +: DIGIT_W];
  endfunction

endpackage

// File: rtl/pair_index_gen.sv
// rtl/pair_index_gen.sv - nested i/j index walker over unordered pairs (i<j) or the full square
module pair_index_gen
  import game_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             load_pairs_i,
  input  logic             load_square_i,
  input  logic             step_i,
  input  logic             full_i,
  output logic [IDX_W-1:0] i_o,
  output logic [IDX_W-1:0] j_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  logic [IDX_W-1:0] i_q;
  logic [IDX_W-1:0] j_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      i_q <= '0;
      j_q <= '0;
    end else if (load_pairs_i) begin
      i_q <= '0;
      j_q <= IDX_W'(1);
    end else if (load_square_i) begin
      i_q <= '0;
      j_q <= '0;
    end else if (step_i) begin
      if (j_q == LAST) begin
        i_q <= i_q + 1'b1;
        // Pair mode restarts j just above the new i.
        j_q <= full_i ? '0 : i_q + IDX_W'(2);
      end else begin
        j_q <= j_q + 1'b1;
      end
    end
  end

  assign i_o    = i_q;
  assign j_o    = j_q;
  assign last_o = full_i ? ((i_q == LAST) && (j_q == LAST))
                         : ((i_q == LAST - 1'b1) && (j_q == LAST));

endmodule

// File: rtl/round_judge_ctrl.sv
// rtl/round_judge_ctrl.sv - one-round 1A2B judge: snapshot, validate, serial A/B scoring, chance bookkeeping
module round_judge_ctrl
  import game_pkg::*;
#(
  parameter int MAX_CHANCES_P = MAX_CHANCES,
  parameter int CNT_W         = 3
) (
  input  logic                      CLOCK_50,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      new_game,
  input  logic [DIGITS*DIGIT_W-1:0] target_i,
  input  logic [DIGITS*DIGIT_W-1:0] guess_i,
  output logic                      busy,
  output logic                      done,
  output logic                      invalid,
  output logic [CNT_W-1:0]          result_a,
  output logic [CNT_W-1:0]          result_b,
  output logic [CNT_W-1:0]          chances_left,
  output logic                      win,
  output logic                      lose
);

  judge_state_t state_q, state_d;

  logic [DIGITS*DIGIT_W-1:0] tgt_q, gss_q;
  logic                      range_err_q, dup_err_q;
  logic [CNT_W-1:0]          acc_a_q, acc_b_q;
  logic                      busy_q, done_q, invalid_q, win_q, lose_q;
  logic [CNT_W-1:0]          result_a_q, result_b_q, chances_q;

  logic             accept, load_square, step, full;
  logic             range_bad, pair_eq, match, check_fail;
  logic [IDX_W-1:0] idx_i, idx_j;
  logic             idx_last;

  pair_index_gen u_pair_index_gen (
    .clk_i         (CLOCK_50),
    .reset_n_i     (reset_n),
    .load_pairs_i  (accept),
    .load_square_i (load_square),
    .step_i        (step),
    .full_i        (full),
    .i_o           (idx_i),
    .j_o           (idx_j),
    .last_o        (idx_last)
  );

  always_comb begin
    range_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (guess_i[DIGIT_W*k +: DIGIT_W] > digit_t'(9)) range_bad = 1'b1;
    end
  end

  assign pair_eq    = (get_digit(gss_q, idx_i) == get_digit(gss_q, idx_j));
  assign match      = (get_digit(gss_q, idx_i) == get_digit(tgt_q, idx_j));
  // Includes the pair under test so the final CHECK cycle can branch on it.
  assign check_fail = range_err_q | dup_err_q | pair_eq;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = CHECK;
        CHECK:   if (idx_last) state_d = check_fail ? DECIDE : COMPARE;
        COMPARE: if (idx_last) state_d = DECIDE;
        DECIDE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    accept      = (state_q == IDLE) && start && !new_game && !win_q && !lose_q;
    load_square = (state_q == CHECK) && idx_last && !check_fail;
    step        = (state_q == CHECK) || (state_q == COMPARE);
    full        = (state_q == COMPARE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      tgt_q       <= '0;
      gss_q       <= '0;
      range_err_q <= 1'b0;
      dup_err_q   <= 1'b0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      invalid_q   <= 1'b0;
      result_a_q  <= '0;
      result_b_q  <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      chances_q   <= CNT_W'(MAX_CHANCES_P);
    end else if (new_game) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      invalid_q  <= 1'b0;
      result_a_q <= '0;
      result_b_q <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      chances_q  <= CNT_W'(MAX_CHANCES_P);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            tgt_q       <= target_i;
            gss_q       <= guess_i;
            range_err_q <= range_bad;
            dup_err_q   <= 1'b0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            busy_q      <= 1'b1;
          end
        end
        CHECK: begin
          if (pair_eq) dup_err_q <= 1'b1;
        end
        COMPARE: begin
          if (match) begin
            if (idx_i == idx_j) acc_a_q <= acc_a_q + 1'b1;
            else                acc_b_q <= acc_b_q + 1'b1;
          end
        end
        DECIDE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          if (range_err_q || dup_err_q) begin
            invalid_q  <= 1'b1;
            result_a_q <= '0;
            result_b_q <= '0;
          end else begin
            invalid_q  <= 1'b0;
            result_a_q <= acc_a_q;
            result_b_q <= acc_b_q;
            if (acc_a_q == CNT_W'(DIGITS)) begin
              win_q <= 1'b1;
            end else if (chances_q <= CNT_W'(1)) begin
              chances_q <= '0;
              lose_q    <= 1'b1;
            end else begin
              chances_q <= chances_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign invalid      = invalid_q;
  assign result_a     = result_a_q;
  assign result_b     = result_b_q;
  assign chances_left = chances_q;
  assign win          = win_q;
  assign lose         = lose_q;

endmodule

// File: tb/tb_round_judge_ctrl.sv
// tb/tb_round_judge_ctrl.sv - directed self-checking bench for round_judge_ctrl
module tb_round_judge_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        start    = 1'b0;
  logic        new_game = 1'b0;
  logic [15:0] target_i = '0;
  logic [15:0] guess_i  = '0;
  logic        busy, done, invalid, win, lose;
  logic [2:0]  result_a, result_b, chances_left;

  int checks = 0;
  int errors = 0;

  round_judge_ctrl dut (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .start        (start),
    .new_game     (new_game),
    .target_i     (target_i),
    .guess_i      (guess_i),
    .busy         (busy),
    .done         (done),
    .invalid      (invalid),
    .result_a     (result_a),
    .result_b     (result_b),
    .chances_left (chances_left),
    .win          (win),
    .lose         (lose)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  // Returns the edge (relative to the start-sampling edge 0) at which done was seen, or -1.
  task automatic run_guess(input logic [15:0] t, input logic [15:0] g, output int lat);
    target_i = t;
    guess_i  = g;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    target_i = 16'h9999;
    guess_i  = 16'h0000;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic expect_quiet(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL %s: done/busy activity seen=%0b expected 0", name, seen); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    checks++;
    if ({busy, done, invalid, win, lose} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, invalid, win, lose}); end
    checks++;
    if ({result_a, result_b} !== 6'd0) begin errors++; $display("FAIL reset_results: got a=%0d b=%0d expected 0 0", result_a, result_b); end
    checks++;
    if (chances_left !== 3'd5) begin errors++; $display("FAIL reset_chances: got %0d expected 5", chances_left); end
  endtask

  task automatic test_valid();
    int lat;
    run_guess(16'h1234, 16'h1243, lat);
    checks++;
    if (lat !== 23) begin errors++; $display("FAIL valid_latency: got %0d expected 23", lat); end
    checks++;
    if ({result_a, result_b, invalid} !== {3'd2, 3'd2, 1'b0}) begin errors++; $display("FAIL valid_result: got a=%0d b=%0d inv=%0b expected 2 2 0", result_a, result_b, invalid); end
    checks++;
    if (chances_left !== 3'd4) begin errors++; $display("FAIL valid_chances: got %0d expected 4", chances_left); end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL valid_done_pulse: got done=%0b busy=%0b expected 0 0", done, busy); end
  endtask

  task automatic test_win();
    int lat;
    pulse_new_game();
    run_guess(16'h1234, 16'h1234, lat);
    checks++;
    if (lat !== 23) begin errors++; $display("FAIL win_latency: got %0d expected 23", lat); end
    checks++;
    if ({result_a, result_b, win, chances_left} !== {3'd4, 3'd0, 1'b1, 3'd5}) begin errors++; $display("FAIL win_result: got a=%0d b=%0d win=%0b ch=%0d expected 4 0 1 5", result_a, result_b, win, chances_left); end
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_quiet("win_start_ignored");
  endtask

  task automatic test_invalid();
    int lat;
    pulse_new_game();
    run_guess(16'h1234, 16'h1243, lat);
    run_guess(16'h1234, 16'h1123, lat);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL dup_latency: got %0d expected 7", lat); end
    checks++;
    if ({invalid, result_a, result_b, chances_left} !== {1'b1, 3'd0, 3'd0, 3'd4}) begin errors++; $display("FAIL dup_result: got inv=%0b a=%0d b=%0d ch=%0d expected 1 0 0 4", invalid, result_a, result_b, chances_left); end
    run_guess(16'h1234, 16'h12A3, lat);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL range_latency: got %0d expected 7", lat); end
    checks++;
    if ({invalid, result_a, result_b, chances_left} !== {1'b1, 3'd0, 3'd0, 3'd4}) begin errors++; $display("FAIL range_result: got inv=%0b a=%0d b=%0d ch=%0d expected 1 0 0 4", invalid, result_a, result_b, chances_left); end
    run_guess(16'h1234, 16'h4321, lat);
    checks++;
    if ({lat == 23, invalid, result_a, result_b, chances_left} !== {1'b1, 1'b0, 3'd0, 3'd4, 3'd3}) begin errors++; $display("FAIL all_b_result: got lat=%0d inv=%0b a=%0d b=%0d ch=%0d expected 23 0 0 4 3", lat, invalid, result_a, result_b, chances_left); end
  endtask

  task automatic test_lose();
    int lat;
    pulse_new_game();
    for (int n = 1; n <= 5; n++) begin
      run_guess(16'h5678, 16'h1234, lat);
      checks++;
      if ({lat == 23, result_a, result_b, chances_left, lose} !== {1'b1, 3'd0, 3'd0, 3'(5 - n), n == 5}) begin
        errors++;
        $display("FAIL lose_round%0d: got lat=%0d a=%0d b=%0d ch=%0d lose=%0b expected 23 0 0 %0d %0b", n, lat, result_a, result_b, chances_left, lose, 5 - n, n == 5);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_quiet("lose_start_ignored");
  endtask

  task automatic test_start_with_new_game();
    start    = 1'b1;
    new_game = 1'b1;
    tick();
    start    = 1'b0;
    new_game = 1'b0;
    checks++;
    if ({lose, chances_left, busy} !== {1'b0, 3'd5, 1'b0}) begin errors++; $display("FAIL same_cycle_state: got lose=%0b ch=%0d busy=%0b expected 0 5 0", lose, chances_left, busy); end
    expect_quiet("same_cycle_no_eval");
  endtask

  task automatic test_abort();
    int lat;
    run_guess(16'h1234, 16'h1243, lat);
    target_i = 16'h1234;
    guess_i  = 16'h1243;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (9) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %0b expected 1", busy); end
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    checks++;
    if ({busy, done, result_a, result_b, chances_left, win, lose} !== {1'b0, 1'b0, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_state: got busy=%0b done=%0b a=%0d b=%0d ch=%0d win=%0b lose=%0b expected 0 0 0 0 5 0 0", busy, done, result_a, result_b, chances_left, win, lose);
    end
    expect_quiet("abort_no_done");
  endtask

  task automatic test_reset_mid();
    target_i = 16'h1234;
    guess_i  = 16'h1243;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({busy, done, chances_left} !== {1'b0, 1'b0, 3'd5}) begin errors++; $display("FAIL reset_mid_state: got busy=%0b done=%0b ch=%0d expected 0 0 5", busy, done, chances_left); end
    expect_quiet("reset_mid_no_done");
  endtask

  initial begin
    test_reset();
    test_valid();
    test_win();
    test_invalid();
    test_lose();
    test_start_with_new_game();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
